bram_sd_sync: RTL and testbench

BRAM_SD_SYNC -- requirements
Module: bram_sd_sync

---
 rtl/bram_sd_sync_pkg.sv | 27 ++
 rtl/edge_det.sv | 23 ++
 rtl/bram_sd_sync.sv | 166 ++++++++++++++++
 tb/tb_bram_sd_sync.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_sd_sync_pkg.sv
// Shared types and constants for the backup-RAM to SD sector sync block.
// Holds the FSM encoding, the format header image and the LBA width.
package bram_sd_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_FORMAT
  } state_e;

  localparam int LBA_W = 32;
  localparam int FMT_N = 4;

  localparam logic [FMT_N-1:0][15:0] FMT_HDR = {
    16'h8010, 16'h8800, 16'h4D42, 16'h5548
  };

  // Words past the header image format to zero.
  function automatic logic [15:0] fmt_word(
    input logic [15:0] a
  );
    if (a < 16'(FMT_N)) return FMT_HDR[a[1:0]];
    return 16'h0000;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Rising/falling edge detector with a reset preset on the history flop.
// Presetting to 1 hides a level that is already high at reset release.
module edge_det #(
  parameter logic PRESET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= PRESET;
    else        prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;
  assign fall_o = ~d_i & prev_q;

endmodule

// File: rtl/bram_sd_sync.sv
// Moves save slots between backup RAM and SD sectors; formats the header.
// Define BKSYNC_AUTOSAVE_EN to add the idle-timer automatic save.
module bram_sd_sync
  import bram_sd_sync_pkg::*;
#(
  parameter int          SECTORS         = 16,
  parameter int          SLOTS           = 4,
  parameter logic [23:0] AUTOSAVE_CYCLES = 24'hFFFFFF,
  parameter int          FMT_WORDS       = 4,
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int IDX_W  = (SECTORS > 1) ? $clog2(SECTORS) : 1,
  localparam int FA_W   = (FMT_WORDS > 1) ? $clog2(FMT_WORDS) : 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              bk_ena,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              format_req,
  input  logic [SLOT_W-1:0] slot,
  input  logic              bram_wr,
  output logic [LBA_W-1:0]  sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  output logic [FA_W-1:0]   fmt_addr,
  output logic [15:0]       fmt_data,
  output logic              fmt_we,
  output logic              busy,
  output logic              loading,
  output logic              dirty
);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [SLOT_W-1:0] slot_q;
  logic [FA_W-1:0]   fcnt_q;
  logic              ld_q;
  logic              rd_q;
  logic              wr_q;
  logic              dirty_q;

  logic ld_rise, sv_rise, fm_rise;
  logic ack_rise, ack_fall;
  logic auto_fire, save_go;
  logic [2:0] unused_fall;

  edge_det #(.PRESET(1'b1)) u_ld (
    .clk(clk_sys), .rst_n(reset_n), .d_i(load_req),
    .rise_o(ld_rise), .fall_o(unused_fall[0])
  );

  edge_det #(.PRESET(1'b1)) u_sv (
    .clk(clk_sys), .rst_n(reset_n), .d_i(save_req),
    .rise_o(sv_rise), .fall_o(unused_fall[1])
  );

  edge_det #(.PRESET(1'b1)) u_fm (
    .clk(clk_sys), .rst_n(reset_n), .d_i(format_req),
    .rise_o(fm_rise), .fall_o(unused_fall[2])
  );

  edge_det #(.PRESET(1'b1)) u_ack (
    .clk(clk_sys), .rst_n(reset_n), .d_i(sd_ack),
    .rise_o(ack_rise), .fall_o(ack_fall)
  );

`ifdef BKSYNC_AUTOSAVE_EN
  logic [23:0] as_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)          as_q <= '0;
    else if (bram_wr)      as_q <= AUTOSAVE_CYCLES;
    else if (as_q != '0)   as_q <= as_q - 24'd1;
  end

  // A timeout that lands while busy is simply lost.
  assign auto_fire = (as_q == 24'd1) & ~bram_wr & dirty_q
                   & bk_ena & (state_q == ST_IDLE);
`else
  logic unused_as;
  assign unused_as = ^AUTOSAVE_CYCLES;
  assign auto_fire = 1'b0;
`endif

  assign save_go = sv_rise | auto_fire;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      slot_q  <= '0;
      fcnt_q  <= '0;
      ld_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bk_ena && (ld_rise || save_go)) begin
            state_q <= ST_REQ;
            idx_q   <= '0;
            slot_q  <= slot;
            ld_q    <= ld_rise;
            rd_q    <= ld_rise;
            wr_q    <= ~ld_rise;
            if (!ld_rise) dirty_q <= 1'b0;
          end else if (fm_rise) begin
            state_q <= ST_FORMAT;
            fcnt_q  <= '0;
          end
        end
        ST_REQ: begin
          if (ack_rise) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= ST_XFER;
          end else if (!bk_ena) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (ack_fall) begin
            if (!bk_ena) begin
              state_q <= ST_IDLE;
            end else if (idx_q == IDX_W'(SECTORS - 1)) begin
              state_q <= ST_IDLE;
              if (ld_q) dirty_q <= 1'b0;
            end else begin
              idx_q   <= idx_q + 1'b1;
              rd_q    <= ld_q;
              wr_q    <= ~ld_q;
              state_q <= ST_REQ;
            end
          end
        end
        ST_FORMAT: begin
          if (fcnt_q == FA_W'(FMT_WORDS - 1)) begin
            state_q <= ST_IDLE;
            dirty_q <= 1'b1;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Core writes always win so a save in flight gets repeated.
      if (bram_wr) dirty_q <= 1'b1;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign loading  = busy & ld_q;
  assign dirty    = dirty_q;
  assign sd_rd    = rd_q;
  assign sd_wr    = wr_q;
  assign sd_lba   = LBA_W'(slot_q) * LBA_W'(SECTORS)
                  + LBA_W'(idx_q);
  assign fmt_we   = (state_q == ST_FORMAT);
  assign fmt_addr = fcnt_q;
  assign fmt_data = fmt_we ? fmt_word(16'(fcnt_q)) : 16'h0000;

endmodule

// File: tb/tb_bram_sd_sync.sv
// Directed bench for bram_sd_sync (SECTORS=16, SLOTS=4, autosave=100).
// Autosave timing is exercised when BKSYNC_AUTOSAVE_EN is defined.
module tb_bram_sd_sync;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        bk_ena = 1'b0;
  logic        load_req = 1'b0;
  logic        save_req = 1'b0;
  logic        format_req = 1'b0;
  logic [1:0]  slot = 2'd0;
  logic        bram_wr = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [1:0]  fmt_addr;
  logic [15:0] fmt_data;
  logic        fmt_we;
  logic        busy, loading, dirty;

  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int fmt_seen = 0;

  logic [15:0] hdr [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

  bram_sd_sync #(
    .SECTORS(16), .SLOTS(4),
    .AUTOSAVE_CYCLES(24'd100), .FMT_WORDS(4)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bk_ena(bk_ena),
    .load_req(load_req), .save_req(save_req),
    .format_req(format_req), .slot(slot), .bram_wr(bram_wr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .fmt_addr(fmt_addr), .fmt_data(fmt_data),
    .fmt_we(fmt_we), .busy(busy), .loading(loading),
    .dirty(dirty)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (sd_wr)  wr_seen++;
    if (sd_rd)  rd_seen++;
    if (fmt_we) fmt_seen++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic do_xfer(input logic ld,
                         input logic [31:0] base,
                         input int n, input int hook,
                         input int tmo);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!(sd_rd || sd_wr) && t < tmo) begin
        @(negedge clk_sys);
        t++;
      end
      chk("strobe_wait", 32'(t < tmo), 1);
      chk("lba", sd_lba, base + i);
      chk("rd", sd_rd, ld);
      chk("wr", sd_wr, !ld);
      chk("loading", loading, ld);
      if (i == hook) begin
        save_req = 1'b0;
        format_req = 1'b1;
        bram_wr = 1'b1;
        @(negedge clk_sys);
        bram_wr = 1'b0;
        save_req = 1'b1;
        chk("hook_hold", sd_rd | sd_wr, 1);
      end
      sd_ack = 1'b1;
      @(negedge clk_sys);
      chk("ack_clr", sd_rd | sd_wr, 0);
      chk("xfer_busy", busy, 1);
      sd_ack = 1'b0;
      @(negedge clk_sys);
      if (i == 15) chk("done_busy", busy, 0);
      else         chk("next_strobe", sd_rd | sd_wr, 1);
    end
  endtask

  initial begin
    int k;
    load_req = 1'b1;
    bk_ena = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_lba", sd_lba, 0);
    chk("rst_strobe", {sd_rd, sd_wr, fmt_we}, 0);
    chk("rst_fmt", {fmt_addr, fmt_data}, 0);
    chk("rst_dirty", dirty, 0);
    cyc(3);
    reset_n = 1'b1;
    cyc(3);
    chk("preset_no_edge", busy, 0);
    load_req = 1'b0;

    // Load of slot 2 with the RAM dirty beforehand.
    bram_wr = 1'b1;
    cyc(1);
    bram_wr = 1'b0;
    chk("pre_dirty", dirty, 1);
    slot = 2'd2;
    load_req = 1'b1;
    cyc(1);
    chk("load_busy", busy, 1);
    chk("load_dirty_kept", dirty, 1);
    do_xfer(1'b1, 32, 16, -1, 20);
    chk("load_dirty_clr", dirty, 0);
    chk("load_loading_off", loading, 0);
    load_req = 1'b0;
    cyc(110);
    chk("quiet_clean", busy, 0);

    // Requests with bk_ena low are dropped; format still runs.
    bk_ena = 1'b0;
    load_req = 1'b1;
    save_req = 1'b1;
    cyc(3);
    chk("bk_off_drop", busy, 0);
    load_req = 1'b0;
    save_req = 1'b0;
    fmt_seen = 0;
    format_req = 1'b1;
    cyc(1);
    for (int j = 0; j < 4; j++) begin
      chk("fmt_we", fmt_we, 1);
      chk("fmt_addr", fmt_addr, j);
      chk("fmt_data", fmt_data, hdr[j]);
      cyc(1);
    end
    chk("fmt_end", fmt_we, 0);
    chk("fmt_dirty", dirty, 1);
    chk("fmt_count", fmt_seen, 4);
    format_req = 1'b0;
    bk_ena = 1'b1;
    cyc(2);

    // Load and save in the same cycle: the load wins.
    wr_seen = 0;
    slot = 2'd1;
    load_req = 1'b1;
    save_req = 1'b1;
    do_xfer(1'b1, 16, 16, -1, 20);
    chk("same_cycle_no_wr", wr_seen, 0);
    load_req = 1'b0;
    save_req = 1'b0;
    cyc(2);

    // Save of slot 3 with a core write at sector 5.
    bram_wr = 1'b1;
    cyc(1);
    bram_wr = 1'b0;
    slot = 2'd3;
    fmt_seen = 0;
    save_req = 1'b1;
    cyc(1);
    chk("save_dirty_clr", dirty, 0);
    do_xfer(1'b0, 48, 16, 5, 20);
    chk("save_dirty_set", dirty, 1);
    chk("busy_fmt_drop", fmt_seen, 0);
    format_req = 1'b0;
`ifdef BKSYNC_AUTOSAVE_EN
    do_xfer(1'b0, 48, 16, -1, 200);
    chk("auto2_dirty", dirty, 0);
`else
    wr_seen = 0;
    rd_seen = 0;
    cyc(150);
    chk("no_autosave", wr_seen + rd_seen, 0);
    chk("no_auto_dirty", dirty, 1);
`endif
    cyc(2);

    // Abort in REQ at sector 3.
    slot = 2'd1;
    load_req = 1'b1;
    do_xfer(1'b1, 16, 3, -1, 20);
    chk("abort_lba_pre", sd_lba, 19);
    bk_ena = 1'b0;
    cyc(1);
    chk("abort_strobe", sd_rd | sd_wr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_loading", loading, 0);
    chk("abort_lba", sd_lba, 19);
    bk_ena = 1'b1;
    cyc(5);
    chk("abort_no_restart", busy, 0);
    load_req = 1'b0;

    // Reset in the middle of a transfer.
    slot = 2'd2;
    save_req = 1'b0;
    cyc(1);
    save_req = 1'b1;
    cyc(1);
    chk("rx_strobe", sd_wr, 1);
    chk("rx_lba", sd_lba, 32);
    bram_wr = 1'b1;
    cyc(1);
    bram_wr = 1'b0;
    chk("rx_dirty", dirty, 1);
    sd_ack = 1'b1;
    cyc(1);
    chk("rx_in_xfer", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rx_rst_busy", busy, 0);
    chk("rx_rst_out", {sd_rd, sd_wr, loading, dirty}, 0);
    chk("rx_rst_lba", sd_lba, 0);
    sd_ack = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    wr_seen = 0;
    rd_seen = 0;
    cyc(10);
    chk("rx_no_reissue", wr_seen + rd_seen, 0);
    chk("rx_idle", busy, 0);

`ifdef BKSYNC_AUTOSAVE_EN
    // Autosave latency from a single core write.
    slot = 2'd1;
    bram_wr = 1'b1;
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
      if (k == 1) bram_wr = 1'b0;
    end while (!sd_wr && k < 300);
    chk("as_latency", 32'(k >= 101 && k <= 102), 1);
    do_xfer(1'b0, 16, 16, -1, 20);
    // A second write at cycle 50 pushes it out by 50.
    bram_wr = 1'b1;
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
      if (k == 1)  bram_wr = 1'b0;
      if (k == 50) bram_wr = 1'b1;
      if (k == 51) bram_wr = 1'b0;
      if (k == 103) chk("as_not_early", sd_wr, 0);
    end while (!sd_wr && k < 400);
    chk("as_postponed", 32'(k >= 151 && k <= 152), 1);
    do_xfer(1'b0, 16, 16, -1, 20);
`else
    wr_seen = 0;
    bram_wr = 1'b1;
    cyc(1);
    bram_wr = 1'b0;
    cyc(200);
    chk("idle_no_save", wr_seen, 0);
    chk("idle_dirty", dirty, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
